pipe_param_adder: RTL and testbench
===================================

// Module: pipe_param_adder
// PURPOSE
//  Parametrised, pipelined successor of the registered 4-bit adder: WIDTH-bit add/subtract with carry/borrow-in,
//  split into STAGES carry-ripple chunks with one register per chunk. Valid-tagged, stallable pipeline.
//  Sits in the datapath wherever wide add/sub must close timing, e.g. accumulators and address generators.
// PARAMETERS
//  WIDTH   16  operand/result width; must be a multiple of STAGES (elaboration error otherwise)
//  STAGES   4  pipeline depth = number of carry chunks; chunk width CW = WIDTH/STAGES; STAGES>=1
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  en         in   1      pipeline advance; 0 = whole pipeline holds (stall)
//  valid_in   in   1      a/b/cin/sub are a valid operation this cycle
//  sub        in   1      0 = a+b+cin; 1 = a-b-cin (cin acts as borrow-in)
//  cin        in   1      carry-in / borrow-in
//  a, b       in   WIDTH  operands (unsigned; ovf gives two's-complement view)
//  valid_out  out  1      sum/cout/ovf hold a completed result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      add: carry-out; sub: 1 = no borrow (a >= b+cin), 0 = borrow
//  ovf        out  1      signed overflow of the WIDTH-bit result
// BEHAVIOUR
//  - Reset: one clock; reset is asynchronous and active-low. While rst=0 all pipeline registers,
//    valid_out, sum, cout, ovf = 0. Reset mid-operation discards every in-flight result; no valid_out
//    until STAGES enabled cycles after the first post-reset valid_in.
//  - Operand conditioning at entry: b_eff = sub ? ~b : b; c_eff = sub ? ~cin : cin. Then sum = a + b_eff + c_eff.
//  - Stage k (0..STAGES-1) adds chunk k of a and b_eff plus carry from stage k-1 (stage 0 uses c_eff),
//    registers its CW-bit result and carry. Higher chunks of a/b_eff are skew-delayed k cycles; lower
//    result chunks are de-skewed so all chunks of one operation emerge together.
//  - Latency: exactly STAGES enabled cycles from valid_in sampled to valid_out=1. Throughput 1/cycle.
//  - en=0: no register changes (including valid bits); outputs hold. en=1 with valid_in=0 inserts a
//    bubble (valid bit 0 propagates; data regs may update, value don't-care when valid_out=0).
//  - cout = carry out of stage STAGES-1. ovf = carry into MSB XOR carry out of MSB (computed in last stage).
//  - Outputs are registered; no combinational path from any input to any output.
//  - STAGES=1 degenerates to a single registered WIDTH-bit adder, latency 1.
//  - Wrap-around: all-ones + 1 -> sum 0, cout 1; 0 - 1 -> sum all-ones, cout 0.
// STRUCTURE
//  - Shared header adder_defs.vh: OP_ADD=1'b0 / OP_SUB=1'b1 constants, CW derivation macro, used by the
//    bench for golden-model mode decode.
//  - One sub-module adder_chunk (CW-bit registered slice: a,b,ci,en -> s,co, plus MSB carry-in tap for ovf),
//    instantiated STAGES times in a generate loop; skew/de-skew shift registers live in the top.
// TESTING (bench drives on negedge, checks against a queue-based golden model delayed STAGES cycles)
//  - Default params, rst=0 then 1, 8 cycles valid_in=0 -> valid_out,sum,cout,ovf all 0 throughout.
//  - WIDTH=16,STAGES=4: a=16'hFFFF,b=16'h0001,cin=0,sub=0 -> 4 cycles later sum=16'h0000,cout=1,ovf=0.
//  - sub=1: a=16'h0000,b=16'h0001,cin=0 -> sum=16'hFFFF,cout=0; a=16'h8000,b=1,cin=0 -> sum=16'h7FFF,ovf=1.
//  - Back-to-back 200 random ops with random en=0 stalls and valid_in gaps -> every result matches
//    {cout,sum}=a+b_eff+c_eff in order, none dropped or duplicated, outputs frozen while en=0.
//  - Assert rst=0 with 3 ops in flight -> outputs 0 immediately (async), no stale valid_out after release.
//  - WIDTH=4,STAGES=1 and WIDTH=8,STAGES=8: exhaustive a,b,cin,sub sweep -> zero mismatches, latency=STAGES.

Source files
------------

// File: rtl/pipe_param_adder_pkg.sv
// Shared constants for the pipelined adder: operation encoding and chunk-width derivation.
// Both the RTL and its golden model decode the sub input through these names.
package pipe_param_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

endpackage

// File: rtl/pipe_param_adder_chunk.sv
// One registered carry-ripple slice of the pipelined adder.
// Registers the slice sum, its carry-out, and the signed-overflow flag of the slice MSB.
module pipe_param_adder_chunk #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co,
    output logic          ovf
);

    logic [CW:0] total;
    logic        c_msb;

    assign total = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign c_msb = total[CW-1] ^ a[CW-1] ^ b[CW-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s   <= '0;
            co  <= 1'b0;
            ovf <= 1'b0;
        end else if (en) begin
            s   <= total[CW-1:0];
            co  <= total[CW];
            ovf <= total[CW] ^ c_msb;
        end
    end

endmodule

// File: rtl/pipe_param_adder.sv
// Pipelined WIDTH-bit add/subtract split into STAGES registered carry chunks.
// Operand chunks are skewed in, result chunks de-skewed out, so each result leaves in one piece.
module pipe_param_adder
    import pipe_param_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_in,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             valid_out,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipe_param_adder: WIDTH must be a positive multiple of STAGES");
    end

    // Handshake: an operation is accepted on a rising edge with en=1 and valid_in=1; valid_out
    // qualifies sum/cout/ovf. There is no backpressure: en=0 freezes every register, bubbles included.
    logic [WIDTH-1:0]  b_eff;
    logic              c_eff;
    logic [STAGES-1:0] valid_pipe;
    logic [STAGES-1:0] valid_next;
    logic [STAGES:0]   carry;
    logic [STAGES-1:0] ovf_tap;
    logic              unused_ovf_taps;

    assign b_eff    = (sub == OP_SUB) ? ~b : b;
    assign c_eff    = (sub == OP_SUB) ? ~cin : cin;
    assign carry[0] = c_eff;

    if (STAGES == 1) begin : g_valid_single
        assign valid_next = valid_in;
    end else begin : g_valid_multi
        assign valid_next = {valid_pipe[STAGES-2:0], valid_in};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_pipe <= '0;
        end else if (en) begin
            valid_pipe <= valid_next;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DSK = STAGES - 1 - k;
        logic [CW-1:0] a_k;
        logic [CW-1:0] b_k;
        logic [CW-1:0] s_k;

        if (k == 0) begin : g_direct
            assign a_k = a[k*CW +: CW];
            assign b_k = b_eff[k*CW +: CW];
        end else begin : g_skew
            // Chunk k waits k cycles so it meets the carry of the same operation.
            logic [CW-1:0] a_dly [k];
            logic [CW-1:0] b_dly [k];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int j = 0; j < k; j++) begin
                        a_dly[j] <= '0;
                        b_dly[j] <= '0;
                    end
                end else if (en) begin
                    a_dly[0] <= a[k*CW +: CW];
                    b_dly[0] <= b_eff[k*CW +: CW];
                    for (int j = 1; j < k; j++) begin
                        a_dly[j] <= a_dly[j-1];
                        b_dly[j] <= b_dly[j-1];
                    end
                end
            end
            assign a_k = a_dly[k-1];
            assign b_k = b_dly[k-1];
        end

        pipe_param_adder_chunk #(.CW(CW)) u_chunk (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .a   (a_k),
            .b   (b_k),
            .ci  (carry[k]),
            .s   (s_k),
            .co  (carry[k+1]),
            .ovf (ovf_tap[k])
        );

        if (DSK == 0) begin : g_no_deskew
            assign sum[k*CW +: CW] = s_k;
        end else begin : g_deskew
            logic [CW-1:0] s_dly [DSK];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int j = 0; j < DSK; j++) begin
                        s_dly[j] <= '0;
                    end
                end else if (en) begin
                    s_dly[0] <= s_k;
                    for (int j = 1; j < DSK; j++) begin
                        s_dly[j] <= s_dly[j-1];
                    end
                end
            end
            assign sum[k*CW +: CW] = s_dly[DSK-1];
        end
    end

    assign valid_out       = valid_pipe[STAGES-1];
    assign cout            = carry[STAGES];
    assign ovf             = ovf_tap[STAGES-1];
    assign unused_ovf_taps = ^ovf_tap;

endmodule

// File: tb/tb_pipe_param_adder.sv
// Bench for pipe_param_adder: 16/4 main instance plus 4/1 and 8/8 instances on shared inputs.
// Expected results come from an arithmetic reference model and a queue of issue deadlines.
module tb_pipe_param_adder;
    import pipe_param_adder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        vin = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic        v16, c16, o16;
    logic [15:0] s16;
    logic        v4, c4, o4;
    logic [3:0]  s4;
    logic        v8, c8, o8;
    logic [7:0]  s8;

    int          n_checks = 0;
    int          n_pass = 0;
    int          ecount = 0;
    logic [17:0] exp_q[$];
    int          exp_t[$];

    always #5 clk = ~clk;

    pipe_param_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .en(en), .valid_in(vin), .sub(sub), .cin(cin), .a(a), .b(b),
        .valid_out(v16), .sum(s16), .cout(c16), .ovf(o16)
    );

    pipe_param_adder #(.WIDTH(4), .STAGES(1)) dut_w4 (
        .clk(clk), .rst(rst), .en(en), .valid_in(vin), .sub(sub), .cin(cin), .a(a[3:0]), .b(b[3:0]),
        .valid_out(v4), .sum(s4), .cout(c4), .ovf(o4)
    );

    pipe_param_adder #(.WIDTH(8), .STAGES(8)) dut_w8 (
        .clk(clk), .rst(rst), .en(en), .valid_in(vin), .sub(sub), .cin(cin), .a(a[7:0]), .b(b[7:0]),
        .valid_out(v8), .sum(s8), .cout(c8), .ovf(o8)
    );

    // Reference: plain unsigned/signed arithmetic on w-bit operands; returns {ovf, cout, sum}.
    function automatic logic [17:0] ref_op(input int w, input logic [15:0] x, input logic [15:0] y,
                                           input logic c, input logic s);
        longint m  = longint'(1) << w;
        longint ux = longint'(x) & (m - 1);
        longint uy = longint'(y) & (m - 1);
        longint sx = (ux >= m / 2) ? ux - m : ux;
        longint sy = (uy >= m / 2) ? uy - m : uy;
        longint uc = longint'(c);
        longint r, sr;
        logic   co;
        if (s == OP_SUB) begin
            r  = ux - uy - uc;
            co = (ux >= uy + uc);
            sr = sx - sy - uc;
        end else begin
            r  = ux + uy + uc;
            co = (r >= m);
            sr = sx + sy + uc;
        end
        return {(sr >= m / 2) || (sr < -(m / 2)), co, 16'(r & (m - 1))};
    endfunction

    // Observed {valid, ovf, cout, sum} of the instance with the given width.
    function automatic logic [18:0] obs(input int w);
        if (w == 4) return {v4, o4, c4, 12'd0, s4};
        if (w == 8) return {v8, o8, c8, 8'd0, s8};
        return {v16, o16, c16, s16};
    endfunction

    // Called at a negedge: applies inputs, takes one rising edge, records accepted ops, returns at negedge.
    task automatic drive(input logic e, input logic v, input logic s, input logic c,
                         input logic [15:0] x, input logic [15:0] y, input int w, input int st);
        en = e; vin = v; sub = s; cin = c; a = x; b = y;
        @(posedge clk);
        if (e) begin
            ecount++;
            if (v) begin
                exp_q.push_back(ref_op(w, x, y, c, s));
                exp_t.push_back(ecount + st - 1);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        en = 1'b0; vin = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete(); exp_t.delete(); ecount = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({v16, o16, c16, s16, v4, o4, c4, s4, v8, o8, c8, s8} !== '0)
            $display("FAIL reset_hold: got %h/%h/%h want all zero", obs(16), obs(4), obs(8));
        else n_pass++;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16, 4);
            n_checks++;
            if (obs(16) !== '0) $display("FAIL idle_after_reset: cycle %0d got %h want 0", i, obs(16));
            else n_pass++;
        end
    endtask

    task automatic test_directed();
        logic [15:0] da[7] = '{16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0005, 16'h0003};
        logic [15:0] db[7] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0003, 16'h0003};
        logic        dc[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        ds[7] = '{OP_ADD, OP_SUB, OP_SUB, OP_ADD, OP_ADD, OP_SUB, OP_SUB};
        logic [15:0] es[7] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h0001, 16'hFFFF};
        logic        ec[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        eo[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, ds[i], dc[i], da[i], db[i], 16, 4);
            for (int j = 0; j < 2; j++) begin
                drive(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 16, 4);
                n_checks++;
                if (v16 !== 1'b0) $display("FAIL early_valid: op %0d cycle %0d got 1 want 0", i, j + 1);
                else n_pass++;
            end
            drive(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 16, 4);
            n_checks++;
            if ({v16, o16, c16, s16} !== {1'b1, eo[i], ec[i], es[i]})
                $display("FAIL directed_op%0d: got v=%b o=%b c=%b s=%h want v=1 o=%b c=%b s=%h",
                         i, v16, o16, c16, s16, eo[i], ec[i], es[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int          issued = 0;
        logic        e, v;
        logic [18:0] prev, cur;
        logic [17:0] exp_v;
        int          t;
        do_reset();
        for (int cyc = 0; cyc < 3000 && (issued < 200 || exp_q.size() != 0); cyc++) begin
            e = ($urandom_range(0, 4) != 0);
            v = (issued < 200) && ($urandom_range(0, 3) != 0);
            if (e && v) issued++;
            prev = obs(16);
            drive(e, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom), 16, 4);
            cur = obs(16);
            n_checks++;
            if (!e) begin
                if (cur !== prev) $display("FAIL stall_hold: got %h want %h", cur, prev);
                else n_pass++;
            end else if (cur[18]) begin
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra: got result %h want no result", cur[17:0]);
                end else begin
                    exp_v = exp_q.pop_front();
                    t = exp_t.pop_front();
                    if (cur[17:0] !== exp_v || ecount != t)
                        $display("FAIL b2b_result: got %h at cycle %0d want %h at cycle %0d",
                                 cur[17:0], ecount, exp_v, t);
                    else n_pass++;
                end
            end else begin
                if (exp_q.size() != 0 && exp_t[0] <= ecount)
                    $display("FAIL b2b_missing: got no result at cycle %0d want %h", ecount, exp_q[0]);
                else n_pass++;
            end
        end
        n_checks++;
        if (exp_q.size() != 0 || issued != 200)
            $display("FAIL b2b_drain: got %0d pending of %0d issued want 0 of 200", exp_q.size(), issued);
        else n_pass++;
    endtask

    task automatic test_reset_in_flight();
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b1, OP_ADD, 1'b0, 16'(i + 1) * 16'h1111, 16'h0101, 16, 4);
        n_checks++;
        if (obs(16) !== {1'b1, 1'b0, 1'b0, 16'h1212})
            $display("FAIL pre_reset_result: got %h want %h", obs(16), {3'b100, 16'h1212});
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (obs(16) !== '0) $display("FAIL async_reset: got %h want 0", obs(16));
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete(); exp_t.delete(); ecount = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 16, 4);
            n_checks++;
            if (v16 !== 1'b0) $display("FAIL stale_valid: cycle %0d got 1 want 0", i);
            else n_pass++;
        end
    endtask

    task automatic test_sweep(input int w, input int st);
        int          n_ops = (w == 4) ? 1024 : 16384;
        logic [7:0]  bset[16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7E, 8'h7F, 8'h80, 8'h81,
                                  8'hFE, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h00, 8'h00};
        logic [15:0] x, y;
        logic        c, s;
        logic [18:0] cur;
        logic [17:0] exp_v;
        int          t;
        bset[14] = 8'($urandom);
        bset[15] = 8'($urandom);
        do_reset();
        for (int i = 0; i < n_ops + st + 2; i++) begin
            x = '0; y = '0; c = 1'b0; s = 1'b0;
            if (i < n_ops && w == 4) begin
                x = 16'(i & 15); y = 16'((i >> 4) & 15); c = i[8]; s = i[9];
            end else if (i < n_ops) begin
                x = 16'(i & 255); y = {8'h00, bset[(i >> 8) & 15]}; c = i[12]; s = i[13];
            end
            drive(1'b1, i < n_ops, s, c, x, y, w, st);
            cur = obs(w);
            n_checks++;
            if (cur[18]) begin
                if (exp_q.size() == 0) begin
                    $display("FAIL sweep%0d_extra: got result %h want no result", w, cur[17:0]);
                end else begin
                    exp_v = exp_q.pop_front();
                    t = exp_t.pop_front();
                    if (cur[17:0] !== exp_v || ecount != t)
                        $display("FAIL sweep%0d_result: got %h at cycle %0d want %h at cycle %0d",
                                 w, cur[17:0], ecount, exp_v, t);
                    else n_pass++;
                end
            end else begin
                if (exp_q.size() != 0 && exp_t[0] <= ecount)
                    $display("FAIL sweep%0d_missing: got no result at cycle %0d want %h", w, ecount, exp_q[0]);
                else n_pass++;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sweep%0d_drain: got %0d pending want 0", w, exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_in_flight();
        test_sweep(4, 1);
        test_sweep(8, 8);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
